uart_cmd_rcv: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/rx_synch.sv | 30 +++
 rtl/uart_cmd_rcv.sv | 135 +++++++++++++
 tb/tb_uart_cmd_rcv.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command receiver.
// Contents:
//   rx_state_t          - receiver FSM states
//   DEFAULT_BAUD_CYCLES - clocks per bit at 50 MHz / 19200 baud
//   UART_DATA_W         - payload width of one UART frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_t;

  localparam int DEFAULT_BAUD_CYCLES = 2604;
  localparam int UART_DATA_W         = 8;

endpackage

// File: rtl/rx_synch.sv
// Two-flop synchronizer for an asynchronous, idle-high input pin.
// Both flops preset to 1 in reset so an idle line never looks like a
// falling edge when reset is released. The same block also suits the
// A2D and inertial MISO pins.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset (presets the chain to 1)
//   d     - asynchronous input
//   q     - synchronized output
module rx_synch (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage metastability filter, preset high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/uart_cmd_rcv.sv
// 8N1 UART receiver for single-byte commands from the BLE module.
// A byte is delivered in rx_data with a rdy/clr_rdy handshake. Start bits
// are re-checked at mid-bit so that line glitches are rejected silently.
// A low stop bit gives a one-cycle frm_err. The receiver then waits for
// the line to return high, so a break never re-triggers a frame.
// Ports:
//   clk     - system clock
//   rst_n   - synchronous active-low reset
//   RX      - asynchronous serial input, idle high
//   clr_rdy - consumer acknowledge; clears rdy and ovr
//   rx_data - last valid received byte
//   rdy     - rx_data holds an unacknowledged byte
//   frm_err - one-cycle pulse: stop bit sampled low
//   ovr     - sticky: a byte completed while rdy was still set
module uart_cmd_rcv
  import uart_pkg::*;
#(
  parameter int BAUD_CYCLES = DEFAULT_BAUD_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RX,
  input  logic                   clr_rdy,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rdy,
  output logic                   frm_err,
  output logic                   ovr
);

  localparam int HALF_CYCLES = BAUD_CYCLES / 2;
  localparam int CNT_W       = $clog2(BAUD_CYCLES);

  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic                   rx_s;
  rx_state_t              state_r;
  logic [CNT_W-1:0]       baud_cnt_r;
  logic [3:0]             bit_cnt_r;
  logic [UART_DATA_W-1:0] shift_r;
  logic                   sample_s;

  rx_synch u_rx_synch (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (RX),
    .q     (rx_s)
  );

  // The counter expires mid-bit; every bit decision is taken on that cycle.
  assign sample_s = (baud_cnt_r == CNT_ZERO);

  // Receiver FSM with baud counter, shifter and registered handshake flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      baud_cnt_r <= CNT_ZERO;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'h00;
      rx_data    <= 8'h00;
      rdy        <= 1'b0;
      frm_err    <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      // Acknowledge; a completing frame below overrides this.
      if (clr_rdy) begin
        rdy <= 1'b0;
        ovr <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r    <= START;
            baud_cnt_r <= HALF_LOAD;
          end
        end
        START: begin
          if (sample_s) begin
            if (!rx_s) begin
              state_r    <= DATA;
              baud_cnt_r <= FULL_LOAD;
              bit_cnt_r  <= 4'd0;
            end else begin
              // The start bit did not survive to mid-bit, so it was a glitch.
              state_r <= IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - CNT_ONE;
          end
        end
        DATA: begin
          if (sample_s) begin
            shift_r    <= {rx_s, shift_r[7:1]};
            bit_cnt_r  <= bit_cnt_r + 4'd1;
            baud_cnt_r <= FULL_LOAD;
            if (bit_cnt_r == 4'd7) begin
              state_r <= STOP;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - CNT_ONE;
          end
        end
        STOP: begin
          if (sample_s) begin
            if (rx_s) begin
              rx_data <= shift_r;
              rdy     <= 1'b1;
              // An acknowledge in this same cycle consumed the old byte,
              // so nothing was overwritten unread.
              ovr     <= clr_rdy ? 1'b0 : (ovr | rdy);
              state_r <= IDLE;
            end else begin
              frm_err <= 1'b1;
              state_r <= WAIT_HI;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (rx_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Self-checking bench for uart_cmd_rcv at BAUD_CYCLES=16.
// It drives 8N1 frames bit by bit and tracks the expected byte, rdy and
// ovr with a small transaction-level model of the handshake rules.
module tb_uart_cmd_rcv;
  import uart_pkg::*;

  localparam int B   = 16;
  localparam int H   = B / 2;
  localparam int LAT = 2 + H + 9 * B;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr;

  int n_cmp = 0;
  int n_bad = 0;
  int frm_cnt = 0;
  int lat;

  logic [7:0] m_data = 8'h00;
  logic       m_rdy = 1'b0;
  logic       m_ovr = 1'b0;
  logic [7:0] rb;

  uart_cmd_rcv #(.BAUD_CYCLES(B)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (rx),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;

  // Count high cycles of frm_err; one pulse of one cycle adds exactly 1.
  always @(negedge clk) if (frm_err === 1'b1) frm_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data"}, 32'(rx_data), 32'(m_data));
    check({tag, ".rdy"},  32'(rdy),     32'(m_rdy));
    check({tag, ".ovr"},  32'(ovr),     32'(m_ovr));
  endtask

  // Reference: a valid frame delivers its byte. It is an overrun only if an
  // unacknowledged byte is lost, i.e. rdy was set and no ack came in the same cycle.
  task automatic model_frame(input logic [7:0] b, input logic ack_same);
    m_ovr  = ack_same ? 1'b0 : (m_ovr | m_rdy);
    m_rdy  = 1'b1;
    m_data = b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame from posedge+1. A low stop bit leaves the line low.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(B);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(B);
    end
    rx = stop;
    idle(B);
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    idle(1);
    clr_rdy = 1'b0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst.data", 32'(rx_data), 32'h00);
    check("rst.rdy", 32'(rdy), 32'd0);
    check("rst.frm", 32'(frm_err), 32'd0);
    check("rst.ovr", 32'(ovr), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Basic frame with latency measurement
    fork
      send_frame(8'h47, 1'b1);
      begin
        lat = 0;
        while (rdy !== 1'b1 && lat < 400) begin
          idle(1);
          lat++;
        end
      end
    join
    model_frame(8'h47, 1'b0);
    check("lat.in_window", 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);
    check_model("b47");
    check("b47.no_frm", 32'(frm_cnt), 32'd0);
    pulse_clr();
    check_model("b47.clr");

    // Short glitch is rejected at mid-start
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(20);
    check("glitch.state", 32'(dut.state_r), 32'(IDLE));
    check_model("glitch");
    check("glitch.no_frm", 32'(frm_cnt), 32'd0);
    send_frame(8'hC3, 1'b1);
    model_frame(8'hC3, 1'b0);
    check_model("bC3");
    pulse_clr();

    // Framing error followed by a held break
    send_frame(8'hFF, 1'b0);
    idle(40);
    check("frm.pulse", 32'(frm_cnt), 32'd1);
    check("frm.state", 32'(dut.state_r), 32'(WAIT_HI));
    check_model("frm");
    rx = 1'b1;
    idle(2 * B);
    send_frame(8'h53, 1'b1);
    model_frame(8'h53, 1'b0);
    check_model("b53");
    pulse_clr();

    // Overrun
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b0);
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b0);
    check_model("ovr");
    pulse_clr();
    check_model("ovr.clr");

    // Acknowledge on the exact stop-sample cycle: completion wins
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b0);
    fork
      send_frame(8'h3C, 1'b1);
      begin
        repeat (LAT) @(posedge clk);
        #1 clr_rdy = 1'b1;
        idle(1);
        clr_rdy = 1'b0;
      end
    join
    model_frame(8'h3C, 1'b1);
    check_model("same_cycle");
    pulse_clr();

    // Random bytes, gaps and acknowledges
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom);
      idle($urandom_range(0, 10));
      send_frame(rb, 1'b1);
      model_frame(rb, 1'b0);
      check_model("rand");
      if ($urandom_range(0, 1) == 1) pulse_clr();
    end
    check("rand.no_frm", 32'(frm_cnt), 32'd1);

    // Reset in the middle of a frame
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (5 * B + H + 3) @(posedge clk);
        #1 rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("mrst.data", 32'(rx_data), 32'h00);
        check("mrst.rdy", 32'(rdy), 32'd0);
        check("mrst.ovr", 32'(ovr), 32'd0);
        check("mrst.frm", 32'(frm_err), 32'd0);
        check("mrst.state", 32'(dut.state_r), 32'(IDLE));
      end
    join
    m_data = 8'h00;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    idle(20 * B);
    send_frame(8'h00, 1'b1);
    model_frame(8'h00, 1'b0);
    check_model("b00");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
